// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures one RC servo/PPM channel. Reports the high time and
// the rise-to-rise period in microseconds, tracks lock, and reverts to the centre
// setpoint when the input goes quiet for too long.
module servo_pulse_decoder #(
    parameter int CLK_DIV    = 6,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 1500,
    parameter int CENTER_US  = 1000,
    parameter int TIMEOUT_US = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ppm_in,
    output logic [15:0] pulse_us,
    output logic [15:0] period_us,
    output logic        valid,
    output logic        err_range,
    output logic        lost,
    output logic        signal_ok
);

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [15:0]     CNT_MAX    = 16'hFFFF;
    localparam logic [15:0]     TO_CNT     = 16'(TIMEOUT_US);
    localparam logic [15:0]     MIN_CNT    = 16'(MIN_US);
    localparam logic [15:0]     MAX_CNT    = 16'(MAX_US);
    localparam logic [15:0]     CENTER_CNT = 16'(CENTER_US);

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    state_t        state;
    logic          sync_a;
    logic          ppm_s;
    logic          ppm_d;
    logic [PW-1:0] presc;
    logic [15:0]   width_cnt;
    logic [15:0]   period_cnt;
    logic [15:0]   hold_w;

    logic          rise;
    logic          fall;
    logic          tick;
    logic [15:0]   width_inc;
    logic [15:0]   period_inc;
    logic          timeout_hit;

    assign rise = ppm_s & ~ppm_d;
    assign fall = ~ppm_s & ppm_d;
    assign tick = (presc == PRESC_LAST);

    // Counter values including this cycle's tick; used both for counting and for
    // capture so an edge landing on a tick still sees the full microsecond.
    assign width_inc  = (tick && width_cnt  != CNT_MAX) ? width_cnt  + 16'd1 : width_cnt;
    assign period_inc = (tick && period_cnt != CNT_MAX) ? period_cnt + 16'd1 : period_cnt;

    // Period counter runs alongside width counter while HIGH, so one compare per state covers both timeouts.
    assign timeout_hit = ((state == HIGH) && (width_cnt  == TO_CNT)) ||
                         ((state == LOW)  && (period_cnt == TO_CNT));

    // Two-flop synchroniser for the asynchronous pin plus one delay stage for edge detect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_a <= 1'b0;
            ppm_s  <= 1'b0;
            ppm_d  <= 1'b0;
        end else begin
            sync_a <= ppm_in;
            ppm_s  <= sync_a;
            ppm_d  <= ppm_s;
        end
    end

    // Microsecond prescaler; realigned on every rise so measurements start on a tick boundary.
    always_ff @(posedge clk) begin
        if (rst || rise || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Measurement FSM with registered result, strobe and lock outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register here, hold_w included, is reset so a reset mid-pulse leaves no stale measurement.
            state      <= WAIT_RISE;
            width_cnt  <= '0;
            period_cnt <= '0;
            hold_w     <= '0;
            pulse_us   <= CENTER_CNT;
            period_us  <= '0;
            valid      <= 1'b0;
            err_range  <= 1'b0;
            lost       <= 1'b0;
            signal_ok  <= 1'b0;
        end else begin
            valid     <= 1'b0;
            err_range <= 1'b0;
            lost      <= 1'b0;
            if (timeout_hit) begin
                // Timeout outranks a coincident rise; that rise is dropped.
                lost       <= signal_ok;
                signal_ok  <= 1'b0;
                pulse_us   <= CENTER_CNT;
                period_us  <= '0;
                width_cnt  <= '0;
                period_cnt <= '0;
                state      <= WAIT_RISE;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            width_cnt  <= '0;
                            period_cnt <= '0;
                            state      <= HIGH;
                        end
                    end
                    HIGH: begin
                        width_cnt  <= width_inc;
                        period_cnt <= period_inc;
                        if (fall) begin
                            hold_w <= width_inc;
                            state  <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            if (hold_w >= MIN_CNT && hold_w <= MAX_CNT) begin
                                pulse_us  <= hold_w;
                                period_us <= period_inc;
                                valid     <= 1'b1;
                                signal_ok <= 1'b1;
                            end else begin
                                err_range <= 1'b1;
                            end
                            width_cnt  <= '0;
                            period_cnt <= '0;
                            state      <= HIGH;
                        end else begin
                            period_cnt <= period_inc;
                        end
                    end
                    default: begin
                        state <= WAIT_RISE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder: drives cycle-exact servo pulse trains into the decoder and
// checks every rise, timeout and reset against a pulse-level reference model.
// Parameters are scaled down (2 clk/us, 100..300 us window, 1000 us timeout) so the
// run stays short while keeping the same relationships as the default build.
module tb_servo_pulse_decoder;

    localparam int D   = 2;
    localparam int MN  = 100;
    localparam int MX  = 300;
    localparam int CTR = 200;
    localparam int TO  = 1000;

    logic        clk;
    logic        rst;
    logic        ppm_in;
    logic [15:0] pulse_us;
    logic [15:0] period_us;
    logic        valid;
    logic        err_range;
    logic        lost;
    logic        signal_ok;

    servo_pulse_decoder #(
        .CLK_DIV   (D),
        .MIN_US    (MN),
        .MAX_US    (MX),
        .CENTER_US (CTR),
        .TIMEOUT_US(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ppm_in   (ppm_in),
        .pulse_us (pulse_us),
        .period_us(period_us),
        .valid    (valid),
        .err_range(err_range),
        .lost     (lost),
        .signal_ok(signal_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event monitor (sampled on the falling edge, away from the active edge)
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_lost = 0;
    int lost_cyc = 0;
    int overlap_cnt = 0;
    int ok_bad_cnt = 0;
    logic ok_prev = 1'b0;
    logic rst_at_edge = 1'b0;

    always @(posedge clk) rst_at_edge = rst;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid === 1'b1) n_valid = n_valid + 1;
        if (err_range === 1'b1) n_err = n_err + 1;
        if (lost === 1'b1) begin
            n_lost = n_lost + 1;
            lost_cyc = cyc;
        end
        if (int'(valid) + int'(err_range) + int'(lost) > 1) overlap_cnt = overlap_cnt + 1;
        if (!rst_at_edge && signal_ok !== ok_prev) begin
            if (signal_ok === 1'b1 && valid !== 1'b1) ok_bad_cnt = ok_bad_cnt + 1;
            if (signal_ok === 1'b0 && lost !== 1'b1) ok_bad_cnt = ok_bad_cnt + 1;
        end
        ok_prev = signal_ok;
    end

    // Reference model: pulse-level view of what the decoder should report
    bit m_pending = 0;   // a high time has been seen since lock/reset and awaits its closing rise
    int m_prev_hi = 0;
    int m_prev_period = 0;
    bit m_ok = 0;
    int m_pulse = CTR;
    int m_period = 0;
    int rise_cyc = 0;

    task automatic check_outputs(input string tag);
        n_cmp++;
        if (int'(pulse_us) > m_pulse + 1 || int'(pulse_us) < m_pulse - 1) begin
            n_bad++;
            $display("FAIL %s pulse_us got %0d expected %0d+/-1", tag, pulse_us, m_pulse);
        end
        n_cmp++;
        if (int'(period_us) > m_period + 1 || int'(period_us) < m_period - 1) begin
            n_bad++;
            $display("FAIL %s period_us got %0d expected %0d+/-1", tag, period_us, m_period);
        end
        n_cmp++;
        if (signal_ok !== m_ok) begin
            n_bad++;
            $display("FAIL %s signal_ok got %b expected %b", tag, signal_ok, m_ok);
        end
    endtask

    // Raise the pin and check the strobe the closing rise should produce.
    task automatic do_rise(input string tag);
        int v0, e0, l0;
        int exp_v, exp_e;
        v0 = n_valid; e0 = n_err; l0 = n_lost;
        exp_v = 0; exp_e = 0;
        if (m_pending) begin
            if (m_prev_hi >= MN && m_prev_hi <= MX) begin
                exp_v    = 1;
                m_pulse  = m_prev_hi;
                m_period = m_prev_period;
                m_ok     = 1;
            end else begin
                exp_e = 1;
            end
        end
        rise_cyc = cyc;
        ppm_in = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_valid - v0 != exp_v) begin
            n_bad++;
            $display("FAIL %s valid strobes got %0d expected %0d", tag, n_valid - v0, exp_v);
        end
        n_cmp++;
        if (n_err - e0 != exp_e) begin
            n_bad++;
            $display("FAIL %s err_range strobes got %0d expected %0d", tag, n_err - e0, exp_e);
        end
        n_cmp++;
        if (n_lost != l0) begin
            n_bad++;
            $display("FAIL %s lost strobes got %0d expected 0", tag, n_lost - l0);
        end
        check_outputs(tag);
        m_pending = 1;
    endtask

    // One full pulse: hi us high then lo us low, both cycle-exact.
    task automatic pulse(input int hi, input int lo, input string tag);
        int v1, e1, l0, exp_l;
        do_rise(tag);
        v1 = n_valid; e1 = n_err; l0 = n_lost;
        repeat (hi * D - 4) @(negedge clk);
        ppm_in = 1'b0;
        repeat (lo * D) @(negedge clk);
        n_cmp++;
        if (n_valid != v1 || n_err != e1) begin
            n_bad++;
            $display("FAIL %s stray strobes got %0d valid %0d err expected 0", tag, n_valid - v1, n_err - e1);
        end
        if (hi + lo >= TO) begin
            exp_l = m_ok ? 1 : 0;
            n_cmp++;
            if (n_lost - l0 != exp_l) begin
                n_bad++;
                $display("FAIL %s lost strobes got %0d expected %0d", tag, n_lost - l0, exp_l);
            end
            if (exp_l == 1) begin
                n_cmp++;
                if (lost_cyc - rise_cyc < TO * D || lost_cyc - rise_cyc > TO * D + 8) begin
                    n_bad++;
                    $display("FAIL %s lost delay got %0d clk expected %0d..%0d", tag,
                             lost_cyc - rise_cyc, TO * D, TO * D + 8);
                end
            end
            m_ok = 0; m_pulse = CTR; m_period = 0; m_pending = 0;
            check_outputs({tag, "_timeout"});
        end else begin
            n_cmp++;
            if (n_lost != l0) begin
                n_bad++;
                $display("FAIL %s lost strobes got %0d expected 0", tag, n_lost - l0);
            end
            m_prev_hi = hi;
            m_prev_period = hi + lo;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ppm_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || err_range !== 1'b0 || lost !== 1'b0) begin
            n_bad++;
            $display("FAIL reset strobes got %b%b%b expected 000", valid, err_range, lost);
        end
        check_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("after_reset");
    endtask

    task automatic test_lock;
        pulse(200, 400, "lock_1");
        pulse(200, 400, "lock_2");
        pulse(200, 400, "lock_3");
    endtask

    task automatic test_range_reject;
        pulse(80, 520, "short_80");
        pulse(240, 360, "after_short");
        pulse(200, 400, "after_240");
    endtask

    task automatic test_boundaries;
        pulse(MN, 500, "min_edge");
        pulse(MX, 300, "max_edge");
        pulse(MX + 2, 300, "max_plus2");
        pulse(200, 400, "after_boundary");
    endtask

    task automatic test_low_timeout;
        pulse(200, 1200, "low_hold");
        pulse(200, 400, "low_resume_1");
        pulse(200, 400, "low_resume_2");
    endtask

    task automatic test_high_timeout;
        pulse(1200, 200, "high_hold");
        pulse(200, 400, "high_resume_1");
        pulse(200, 400, "high_resume_2");
    endtask

    task automatic test_reset_mid_pulse;
        int v0, e0;
        pulse(200, 400, "mid_lock");
        do_rise("mid_rise");
        repeat (140 * D - 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_ok = 0; m_pulse = CTR; m_period = 0;
        n_cmp++;
        if (valid !== 1'b0 || err_range !== 1'b0 || lost !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset strobes got %b%b%b expected 000", valid, err_range, lost);
        end
        check_outputs("mid_reset");
        rst = 1'b0;
        // The pin is still high, so the freshly cleared synchroniser sees a rise and
        // measures only the remaining ~60 us, which is below the accepted window.
        m_pending = 1; m_prev_hi = 60; m_prev_period = 460;
        v0 = n_valid; e0 = n_err;
        repeat (60 * D - 1) @(negedge clk);
        ppm_in = 1'b0;
        repeat (400 * D) @(negedge clk);
        n_cmp++;
        if (n_valid != v0 || n_err != e0) begin
            n_bad++;
            $display("FAIL mid_tail stray strobes got %0d valid %0d err expected 0", n_valid - v0, n_err - e0);
        end
        pulse(200, 400, "mid_after_1");
        pulse(200, 400, "mid_after_2");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            pulse(int'($urandom_range(60, 340)), int'($urandom_range(150, 500)), "random");
        end
    endtask

    task automatic test_invariants;
        n_cmp++;
        if (overlap_cnt != 0) begin
            n_bad++;
            $display("FAIL strobe_overlap got %0d expected 0", overlap_cnt);
        end
        n_cmp++;
        if (ok_bad_cnt != 0) begin
            n_bad++;
            $display("FAIL signal_ok_change got %0d unexplained expected 0", ok_bad_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        ppm_in = 1'b0;
        test_reset();
        test_lock();
        test_range_reject();
        test_boundaries();
        test_low_timeout();
        test_high_timeout();
        test_reset_mid_pulse();
        test_random();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
